// File: rtl/writeback_if.sv
// Writeback stage bus: instruction/result inputs from the previous stage and
// register-file, redirect, trap and stall outputs. master drives the stage
// inputs; slave is the writeback stage itself.
// Handshake: WB_V qualifies every WB_* input on the rising clock edge. WB_STALL
// is the only back-pressure. While it is high the stage ignores its inputs, and
// the upstream stage must hold its instruction.
interface writeback_if;
    logic        WB_V;
    logic [31:0] WB_IR;
    logic [63:0] WB_NPC;
    logic [63:0] WB_ALU_RESULT;
    logic [63:0] WB_MEM_RESULT;
    logic [63:0] WB_CSRFD;
    logic        WB_PC_MUX;
    logic        WB_ECALL;
    logic [63:0] CSR_TVEC;
    logic        RF_WE;
    logic [4:0]  RF_DR;
    logic [63:0] RF_DATA;
    logic        BR_TAKEN;
    logic [63:0] BR_TARGET;
    logic        FLUSH;
    logic        TRAP_VALID;
    logic [63:0] TRAP_EPC;
    logic        WB_STALL;
    logic [63:0] INSTRET;
    logic [1:0]  DBG_STATE;

    modport master (
        output WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
               WB_PC_MUX, WB_ECALL, CSR_TVEC,
        input  RF_WE, RF_DR, RF_DATA, BR_TAKEN, BR_TARGET, FLUSH, TRAP_VALID,
               TRAP_EPC, WB_STALL, INSTRET, DBG_STATE
    );

    modport slave (
        input  WB_V, WB_IR, WB_NPC, WB_ALU_RESULT, WB_MEM_RESULT, WB_CSRFD,
               WB_PC_MUX, WB_ECALL, CSR_TVEC,
        output RF_WE, RF_DR, RF_DATA, BR_TAKEN, BR_TARGET, FLUSH, TRAP_VALID,
               TRAP_EPC, WB_STALL, INSTRET, DBG_STATE
    );
endinterface

// File: rtl/writeback.sv
// Writeback stage. It produces the register-file write, the branch redirect and
// the ECALL trap sequence (IDLE -> TRAP -> DRAIN -> IDLE).
// Optional feature macro: WB_INSTRET_EN enables the retired-instruction counter.
// When the macro is undefined, INSTRET reads as constant 0.
module writeback (
    input  logic  CLK,
    input  logic  RESET,
    writeback_if.slave wb
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] TRAP  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_REG32  = 7'b0111011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [1:0]  state_q, state_d;
    logic        rf_we_q, rf_we_d;
    logic [4:0]  rf_dr_q, rf_dr_d;
    logic [63:0] rf_data_q, rf_data_d;
    logic        br_taken_q, br_taken_d;
    logic [63:0] br_target_q, br_target_d;
    logic        flush_q, flush_d;
    logic        trap_valid_q, trap_valid_d;
    logic [63:0] trap_epc_q, trap_epc_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic        writes_rd;
    logic [63:0] load_data;
    logic [63:0] result;
    logic        unused_ir;

    assign opcode    = wb.WB_IR[6:0];
    assign rd        = wb.WB_IR[11:7];
    assign funct3    = wb.WB_IR[14:12];
    assign unused_ir = ^wb.WB_IR[31:15];

    // Decode whether the instruction class writes a destination register
    always_comb begin
        writes_rd = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_IMM, OP_REG, OP_IMM32, OP_REG32,
            OP_LOAD, OP_JAL, OP_JALR: writes_rd = 1'b1;
            OP_SYSTEM:                writes_rd = (funct3 != 3'b000);
            default:                  writes_rd = 1'b0;
        endcase
    end

    // Align and extend load data; the upper memory bits are don't-care
    always_comb begin
        load_data = wb.WB_MEM_RESULT;
        case (funct3)
            3'b000:  load_data = {{56{wb.WB_MEM_RESULT[7]}},  wb.WB_MEM_RESULT[7:0]};
            3'b001:  load_data = {{48{wb.WB_MEM_RESULT[15]}}, wb.WB_MEM_RESULT[15:0]};
            3'b010:  load_data = {{32{wb.WB_MEM_RESULT[31]}}, wb.WB_MEM_RESULT[31:0]};
            3'b100:  load_data = {56'd0, wb.WB_MEM_RESULT[7:0]};
            3'b101:  load_data = {48'd0, wb.WB_MEM_RESULT[15:0]};
            3'b110:  load_data = {32'd0, wb.WB_MEM_RESULT[31:0]};
            default: load_data = wb.WB_MEM_RESULT;
        endcase
    end

    // Select the register write data by instruction class
    always_comb begin
        result = wb.WB_ALU_RESULT;
        if (opcode == OP_LOAD)
            result = load_data;
        else if (opcode == OP_JAL || opcode == OP_JALR)
            result = wb.WB_NPC;
        else if (opcode == OP_SYSTEM && funct3 != 3'b000)
            result = wb.WB_CSRFD;
    end

    // Next-state and next-output logic; pulses default low, data fields hold
    always_comb begin
        state_d      = state_q;
        rf_we_d      = 1'b0;
        rf_dr_d      = rf_dr_q;
        rf_data_d    = rf_data_q;
        br_taken_d   = 1'b0;
        br_target_d  = br_target_q;
        flush_d      = 1'b0;
        trap_valid_d = 1'b0;
        trap_epc_d   = trap_epc_q;
        case (state_q)
            IDLE: begin
                rf_dr_d   = rd;
                rf_data_d = result;
                if (wb.WB_V && wb.WB_ECALL) begin
                    // ECALL wins over a simultaneous branch: no write, no redirect yet
                    state_d    = TRAP;
                    trap_epc_d = wb.WB_NPC - 64'd4;
                end else begin
                    rf_we_d     = wb.WB_V && writes_rd && (rd != 5'd0);
                    br_taken_d  = wb.WB_V && wb.WB_PC_MUX;
                    flush_d     = wb.WB_V && wb.WB_PC_MUX;
                    br_target_d = wb.WB_ALU_RESULT;
                end
            end
            TRAP: begin
                state_d      = DRAIN;
                trap_valid_d = 1'b1;
                br_taken_d   = 1'b1;
                flush_d      = 1'b1;
                br_target_d  = wb.CSR_TVEC;
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and state registers
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            rf_we_q      <= 1'b0;
            rf_dr_q      <= 5'd0;
            rf_data_q    <= 64'd0;
            br_taken_q   <= 1'b0;
            br_target_q  <= 64'd0;
            flush_q      <= 1'b0;
            trap_valid_q <= 1'b0;
            trap_epc_q   <= 64'd0;
        end else begin
            state_q      <= state_d;
            rf_we_q      <= rf_we_d;
            rf_dr_q      <= rf_dr_d;
            rf_data_q    <= rf_data_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            flush_q      <= flush_d;
            trap_valid_q <= trap_valid_d;
            trap_epc_q   <= trap_epc_d;
        end
    end

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q, instret_d;

    // Count instructions retired in IDLE; ECALLs do not retire here
    always_comb begin
        instret_d = instret_q;
        if (state_q == IDLE && wb.WB_V && !wb.WB_ECALL)
            instret_d = instret_q + 64'd1;
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            instret_q <= 64'd0;
        else
            instret_q <= instret_d;
    end

    assign wb.INSTRET = instret_q;
`else
    assign wb.INSTRET = 64'd0;
`endif

    assign wb.RF_WE      = rf_we_q;
    assign wb.RF_DR      = rf_dr_q;
    assign wb.RF_DATA    = rf_data_q;
    assign wb.BR_TAKEN   = br_taken_q;
    assign wb.BR_TARGET  = br_target_q;
    assign wb.FLUSH      = flush_q;
    assign wb.TRAP_VALID = trap_valid_q;
    assign wb.TRAP_EPC   = trap_epc_q;
    assign wb.WB_STALL   = (state_q != IDLE);
    assign wb.DBG_STATE  = state_q;
endmodule

// File: tb/tb_writeback.sv
// Bench for the writeback stage: a table of single-cycle vectors followed by
// hand-written ECALL, reset-in-trap and INSTRET wrap sequences.
module tb_writeback;
  logic CLK;
  logic RESET;
  writeback_if wbi ();

  writeback dut (.CLK(CLK), .RESET(RESET), .wb(wbi.slave));

  // ---------------- clock / reset ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [63:0] exp_instret;

  typedef struct packed {
    logic        v;
    logic [31:0] ir;
    logic [63:0] npc;
    logic [63:0] alu;
    logic [63:0] mem;
    logic [63:0] csrfd;
    logic        pc_mux;
    logic        exp_we;
    logic [4:0]  exp_dr;
    logic [63:0] exp_data;
    logic        exp_br;
  } vec_t;

  vec_t vecs [0:14];

  function automatic logic [31:0] mk_ir(logic [6:0] op, logic [4:0] rd, logic [2:0] f3);
    return {17'h0ABCD, f3, rd, op};
  endfunction

  function automatic vec_t mk(logic v, logic [31:0] ir, logic [63:0] npc, logic [63:0] alu,
                              logic [63:0] mem, logic [63:0] csrfd, logic pc_mux,
                              logic exp_we, logic [4:0] exp_dr, logic [63:0] exp_data,
                              logic exp_br);
    vec_t r;
    r.v = v; r.ir = ir; r.npc = npc; r.alu = alu; r.mem = mem; r.csrfd = csrfd;
    r.pc_mux = pc_mux; r.exp_we = exp_we; r.exp_dr = exp_dr; r.exp_data = exp_data;
    r.exp_br = exp_br;
    return r;
  endfunction

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"},  {63'd0, wbi.WB_STALL},   64'd0);
    check({tag, "_we"},     {63'd0, wbi.RF_WE},      64'd0);
    check({tag, "_dr"},     {59'd0, wbi.RF_DR},      64'd0);
    check({tag, "_data"},   wbi.RF_DATA,             64'd0);
    check({tag, "_br"},     {63'd0, wbi.BR_TAKEN},   64'd0);
    check({tag, "_tgt"},    wbi.BR_TARGET,           64'd0);
    check({tag, "_flush"},  {63'd0, wbi.FLUSH},      64'd0);
    check({tag, "_trapv"},  {63'd0, wbi.TRAP_VALID}, 64'd0);
    check({tag, "_epc"},    wbi.TRAP_EPC,            64'd0);
    check({tag, "_instret"}, wbi.INSTRET,            64'd0);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    wbi.WB_V = 1'b0; wbi.WB_IR = 32'd0; wbi.WB_NPC = 64'd0; wbi.WB_ALU_RESULT = 64'd0;
    wbi.WB_MEM_RESULT = 64'd0; wbi.WB_CSRFD = 64'd0; wbi.WB_PC_MUX = 1'b0;
    wbi.WB_ECALL = 1'b0; wbi.CSR_TVEC = 64'd0;
  endtask

  task automatic drive_vec(input vec_t t);
    wbi.WB_V = t.v; wbi.WB_IR = t.ir; wbi.WB_NPC = t.npc; wbi.WB_ALU_RESULT = t.alu;
    wbi.WB_MEM_RESULT = t.mem; wbi.WB_CSRFD = t.csrfd; wbi.WB_PC_MUX = t.pc_mux;
    wbi.WB_ECALL = 1'b0;
    exp_q.push_back(t.exp_data);
`ifdef WB_INSTRET_EN
    if (t.v) exp_instret = exp_instret + 64'd1;
`endif
  endtask

  task automatic drive_ecall(input logic [63:0] npc, input logic [63:0] tvec);
    wbi.WB_V = 1'b1; wbi.WB_IR = 32'h0000_0073; wbi.WB_NPC = npc;
    wbi.WB_ALU_RESULT = 64'hDEAD_0000; wbi.WB_PC_MUX = 1'b1; wbi.WB_ECALL = 1'b1;
    wbi.CSR_TVEC = tvec;
  endtask

  // Runs the three-cycle trap sequence from the ECALL edge; inputs in TRAP/DRAIN are junk
  task automatic ecall_seq(input string tag, input logic [63:0] npc, input logic [63:0] tvec);
    logic [63:0] epc;
    epc = npc - 64'd4;
    drive_ecall(npc, tvec);
    @(negedge CLK);
    check({tag, "_t_stall"}, {63'd0, wbi.WB_STALL}, 64'd1);
    check({tag, "_t_epc"},   wbi.TRAP_EPC, epc);
    check({tag, "_t_we"},    {63'd0, wbi.RF_WE}, 64'd0);
    check({tag, "_t_br"},    {63'd0, wbi.BR_TAKEN}, 64'd0);
    check({tag, "_t_flush"}, {63'd0, wbi.FLUSH}, 64'd0);
    check({tag, "_t_trapv"}, {63'd0, wbi.TRAP_VALID}, 64'd0);
    // junk that would write and branch if not ignored
    wbi.WB_ECALL = 1'b0; wbi.WB_IR = mk_ir(7'b0110011, 5'd9, 3'd0);
    wbi.WB_ALU_RESULT = 64'h1111; wbi.WB_NPC = 64'h7774;
    @(negedge CLK);
    check({tag, "_d_stall"}, {63'd0, wbi.WB_STALL}, 64'd1);
    check({tag, "_d_trapv"}, {63'd0, wbi.TRAP_VALID}, 64'd1);
    check({tag, "_d_br"},    {63'd0, wbi.BR_TAKEN}, 64'd1);
    check({tag, "_d_flush"}, {63'd0, wbi.FLUSH}, 64'd1);
    check({tag, "_d_tgt"},   wbi.BR_TARGET, tvec);
    check({tag, "_d_we"},    {63'd0, wbi.RF_WE}, 64'd0);
    check({tag, "_d_epc"},   wbi.TRAP_EPC, epc);
    check({tag, "_d_instret"}, wbi.INSTRET, exp_instret);
    @(negedge CLK);
    drive_idle();
    check({tag, "_i_stall"}, {63'd0, wbi.WB_STALL}, 64'd0);
    check({tag, "_i_trapv"}, {63'd0, wbi.TRAP_VALID}, 64'd0);
    check({tag, "_i_br"},    {63'd0, wbi.BR_TAKEN}, 64'd0);
    check({tag, "_i_flush"}, {63'd0, wbi.FLUSH}, 64'd0);
    check({tag, "_i_we"},    {63'd0, wbi.RF_WE}, 64'd0);
    check({tag, "_i_epc"},   wbi.TRAP_EPC, epc);
    check({tag, "_i_instret"}, wbi.INSTRET, exp_instret);
  endtask

  // ---------------- test ----------------
  initial begin
    logic [63:0] got;
    drive_idle();
    exp_instret = 64'd0;
    RESET = 1'b1;

    // opcodes: LOAD 0000011, JAL 1101111, JALR 1100111, OP-IMM 0010011,
    // SYSTEM 1110011, OP 0110011, BRANCH 1100011, LUI 0110111
    vecs[0]  = mk(1, mk_ir(7'b0000011, 5'd5, 3'd0), 64'h10, 64'h0, 64'h1234_5678_9ABC_DE80, 64'h0, 0,
                  1, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 0);
    vecs[1]  = mk(1, mk_ir(7'b0000011, 5'd5, 3'd4), 64'h10, 64'h0, 64'h1234_5678_9ABC_DE80, 64'h0, 0,
                  1, 5'd5, 64'h80, 0);
    vecs[2]  = mk(1, mk_ir(7'b0000011, 5'd6, 3'd1), 64'h10, 64'h0, 64'h0000_0000_0000_8001, 64'h0, 0,
                  1, 5'd6, 64'hFFFF_FFFF_FFFF_8001, 0);
    vecs[3]  = mk(1, mk_ir(7'b0000011, 5'd7, 3'd2), 64'h10, 64'h0, 64'hAAAA_AAAA_7FFF_FFFF, 64'h0, 0,
                  1, 5'd7, 64'h0000_0000_7FFF_FFFF, 0);
    vecs[4]  = mk(1, mk_ir(7'b0000011, 5'd8, 3'd3), 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001, 64'h0, 0,
                  1, 5'd8, 64'hDEAD_BEEF_0000_0001, 0);
    vecs[5]  = mk(1, mk_ir(7'b0000011, 5'd9, 3'd6), 64'h10, 64'h0, 64'h1111_1111_8000_0000, 64'h0, 0,
                  1, 5'd9, 64'h0000_0000_8000_0000, 0);
    vecs[6]  = mk(1, mk_ir(7'b0000011, 5'd10, 3'd5), 64'h10, 64'h0, 64'hFFFF_FFFF_FFFF_8001, 64'h0, 0,
                  1, 5'd10, 64'h8001, 0);
    vecs[7]  = mk(1, mk_ir(7'b1101111, 5'd1, 3'd0), 64'h1004, 64'h2000, 64'h0, 64'h0, 1,
                  1, 5'd1, 64'h1004, 1);
    vecs[8]  = mk(1, mk_ir(7'b0010011, 5'd0, 3'd0), 64'h1008, 64'h7, 64'h0, 64'h0, 0,
                  0, 5'd0, 64'h7, 0);
    vecs[9]  = mk(1, mk_ir(7'b1110011, 5'd3, 3'd1), 64'h20, 64'h99, 64'h0, 64'h55, 0,
                  1, 5'd3, 64'h55, 0);
    vecs[10] = mk(1, mk_ir(7'b1110011, 5'd3, 3'd0), 64'h24, 64'h99, 64'h0, 64'h55, 0,
                  0, 5'd3, 64'h99, 0);
    vecs[11] = mk(0, mk_ir(7'b0110011, 5'd10, 3'd0), 64'h28, 64'h42, 64'h0, 64'h0, 1,
                  0, 5'd10, 64'h42, 0);
    vecs[12] = mk(1, mk_ir(7'b1100011, 5'd5, 3'd0), 64'h2C, 64'h3000, 64'h0, 64'h0, 1,
                  0, 5'd5, 64'h3000, 1);
    vecs[13] = mk(1, mk_ir(7'b0110111, 5'd7, 3'd0), 64'h30, 64'h1000, 64'h0, 64'h0, 0,
                  1, 5'd7, 64'h1000, 0);
    vecs[14] = mk(1, mk_ir(7'b1100111, 5'd2, 3'd0), 64'h40, 64'h500, 64'h0, 64'h0, 1,
                  1, 5'd2, 64'h40, 1);

    // reset state
    repeat (2) @(negedge CLK);
    check_all_zero("rst");
    RESET = 1'b0;

    // table-driven single-cycle vectors
    for (int i = 0; i < 15; i++) begin
      drive_vec(vecs[i]);
      @(negedge CLK);
      got = exp_q.pop_front();
      check($sformatf("v%0d_we", i),    {63'd0, wbi.RF_WE}, {63'd0, vecs[i].exp_we});
      check($sformatf("v%0d_dr", i),    {59'd0, wbi.RF_DR}, {59'd0, vecs[i].exp_dr});
      check($sformatf("v%0d_data", i),  wbi.RF_DATA, got);
      check($sformatf("v%0d_br", i),    {63'd0, wbi.BR_TAKEN}, {63'd0, vecs[i].exp_br});
      check($sformatf("v%0d_flush", i), {63'd0, wbi.FLUSH}, {63'd0, vecs[i].exp_br});
      if (vecs[i].exp_br)
        check($sformatf("v%0d_tgt", i), wbi.BR_TARGET, vecs[i].alu);
      check($sformatf("v%0d_trapv", i), {63'd0, wbi.TRAP_VALID}, 64'd0);
      check($sformatf("v%0d_stall", i), {63'd0, wbi.WB_STALL}, 64'd0);
      check($sformatf("v%0d_instret", i), wbi.INSTRET, exp_instret);
    end
    drive_idle();
    @(negedge CLK);
    check("idle_br_drop", {63'd0, wbi.BR_TAKEN}, 64'd0);
    check("idle_we_drop", {63'd0, wbi.RF_WE}, 64'd0);

    // ECALL with a simultaneous branch: trap wins
    ecall_seq("ecall", 64'h3004, 64'h8000);

    // reset asserted mid-trap
    drive_ecall(64'h4004, 64'h9000);
    @(negedge CLK);
    check("rtrap_stall_pre", {63'd0, wbi.WB_STALL}, 64'd1);
    #2 RESET = 1'b1;
    #1;
    check_all_zero("rtrap");
    exp_instret = 64'd0;
    drive_idle();
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    ecall_seq("ecall2", 64'h5008, 64'hA000);

    // INSTRET wrap
`ifdef WB_INSTRET_EN
    force dut.instret_d = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge CLK);
    release dut.instret_d;
    #1;
    check("wrap_preload", wbi.INSTRET, 64'hFFFF_FFFF_FFFF_FFFF);
    exp_instret = 64'd0;
`endif
    wbi.WB_V = 1'b1; wbi.WB_IR = mk_ir(7'b0110011, 5'd4, 3'd0); wbi.WB_ALU_RESULT = 64'h77;
    @(negedge CLK);
    drive_idle();
    check("wrap_instret", wbi.INSTRET, exp_instret);
    check("wrap_add_we", {63'd0, wbi.RF_WE}, 64'd1);
    check("wrap_add_data", wbi.RF_DATA, 64'h77);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
